// File: rtl/mac_product_accumulator.sv
// Streaming accumulator: sums LEN multiplier products into an ACC_W-bit result behind valid/ready handshakes.
// Optional MAC_SATURATE_EN clamps the running sum at 2^ACC_W-1 instead of wrapping.
module mac_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              overflow
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // prod_ready depends only on state; acc_valid is exactly "state is HOLD", so it doubles as the state view.
    typedef enum logic {ACC, HOLD} state_t;

    state_t            state, state_next;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  sum_add;
    logic              carry;
    logic              accept;
    logic              last_term;

    assign prod_ready = (state == ACC);
    assign acc_valid  = (state == HOLD);
    assign accept     = prod_valid & prod_ready;
    assign last_term  = (term_cnt == CNT_W'(LEN - 1));

    always_comb begin
        sum_wide = {1'b0, sum} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
        carry    = sum_wide[ACC_W];
`ifdef MAC_SATURATE_EN
        // Once clamped, any further nonzero term carries again, so the sum stays pinned.
        sum_add  = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
        sum_add  = sum_wide[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && last_term) state_next = HOLD;
            HOLD:    if (acc_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
        if (clear) state_next = ACC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            sum      <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
            acc_out  <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                sum      <= '0;
                term_cnt <= '0;
                overflow <= 1'b0;
            end else if (state == HOLD) begin
                if (acc_ready) begin
                    sum      <= '0;
                    term_cnt <= '0;
                    overflow <= 1'b0;
                end
            end else if (accept) begin
                overflow <= overflow | carry;
                sum      <= sum_add;
                if (last_term) begin
                    acc_out  <= sum_add;
                    term_cnt <= CNT_W'(LEN);
                end else begin
                    term_cnt <= term_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Bench for mac_product_accumulator: a 24-bit and an 18-bit instance share stimulus and are
// compared every cycle against a sum-of-terms model; directed literal checks pin the model.
module tb_mac_product_accumulator;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        clear = 1'b0;
    logic        acc_ready = 1'b0;

    logic        a_prod_ready, a_acc_valid, a_overflow;
    logic [23:0] a_acc_out;
    logic [3:0]  a_term_cnt;
    logic        b_prod_ready, b_acc_valid, b_overflow;
    logic [17:0] b_acc_out;
    logic [3:0]  b_term_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(LEN)) dut_a (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(a_prod_ready), .clear(clear), .acc_out(a_acc_out),
        .acc_valid(a_acc_valid), .acc_ready(acc_ready), .term_cnt(a_term_cnt),
        .overflow(a_overflow)
    );

    mac_product_accumulator #(.PROD_W(16), .ACC_W(18), .LEN(LEN)) dut_b (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(b_prod_ready), .clear(clear), .acc_out(b_acc_out),
        .acc_valid(b_acc_valid), .acc_ready(acc_ready), .term_cnt(b_term_cnt),
        .overflow(b_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current result is just the list of accepted terms, kept as an exact total.
    logic [63:0] cur_total = '0;
    int          cur_n = 0;
    bit          m_hold = 1'b0;
    logic [63:0] last_total = '0;
    bit          started = 1'b0;

    function automatic logic [63:0] fold(input logic [63:0] t, input int w);
        logic [63:0] lim;
        lim = 64'(1) << w;
`ifdef MAC_SATURATE_EN
        return (t >= lim) ? lim - 1 : t;
`else
        return t % lim;
`endif
    endfunction

    function automatic bit ovf(input int w);
        return (m_hold ? last_total : cur_total) >= (64'(1) << w);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cur_total = 0; cur_n = 0; m_hold = 0; last_total = 0;
        end else if (clear) begin
            cur_total = 0; cur_n = 0; m_hold = 0;
        end else if (m_hold) begin
            if (acc_ready) begin
                m_hold = 0; cur_total = 0; cur_n = 0;
            end
        end else if (prod_valid) begin
            cur_total += 64'(prod_in);
            cur_n++;
            if (cur_n == LEN) begin
                last_total = cur_total;
                m_hold = 1;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("a_prod_ready", 64'(a_prod_ready), 64'(!m_hold));
            check("a_acc_valid",  64'(a_acc_valid),  64'(m_hold));
            check("a_term_cnt",   64'(a_term_cnt),   m_hold ? 64'(LEN) : 64'(cur_n));
            check("a_acc_out",    64'(a_acc_out),    fold(last_total, 24));
            check("a_overflow",   64'(a_overflow),   64'(ovf(24)));
            check("b_prod_ready", 64'(b_prod_ready), 64'(!m_hold));
            check("b_acc_valid",  64'(b_acc_valid),  64'(m_hold));
            check("b_term_cnt",   64'(b_term_cnt),   m_hold ? 64'(LEN) : 64'(cur_n));
            check("b_acc_out",    64'(b_acc_out),    fold(last_total, 18));
            check("b_overflow",   64'(b_overflow),   64'(ovf(18)));
        end
    end

    // Inputs change 1 time unit after a rising edge and are consumed by the next one.
    task automatic drive(input bit v, input logic [15:0] d, input bit ar, input bit cl, input bit r);
        prod_valid = v;
        prod_in    = d;
        acc_ready  = ar;
        clear      = cl;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] gap_vals [8] = '{16'd3, 16'd0, 16'd7, 16'd12, 16'd0, 16'd255, 16'd9, 16'd1};

    initial begin
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check("rst_acc_out", 64'(a_acc_out), 0);
        check("rst_term_cnt", 64'(a_term_cnt), 0);
        check("rst_prod_ready", 64'(a_prod_ready), 1);

        // Basic sum and overflow on the narrow instance
        for (int i = 0; i < LEN; i++) drive(1, 16'd65025, 0, 0, 0);
        check("basic_valid", 64'(a_acc_valid), 1);
        check("basic_sum", 64'(a_acc_out), 64'd520200);
        check("basic_ovf", 64'(a_overflow), 0);
        check("basic_cnt", 64'(a_term_cnt), 8);
`ifdef MAC_SATURATE_EN
        check("narrow_sum", 64'(b_acc_out), 64'd262143);
`else
        check("narrow_sum", 64'(b_acc_out), 64'd258056);
`endif
        check("narrow_ovf", 64'(b_overflow), 1);

        // Backpressure: offered products are refused while the result is held
        for (int i = 0; i < 5; i++) drive(1, 16'd5, 0, 0, 0);
        check("bp_sum", 64'(a_acc_out), 64'd520200);
        check("bp_ready", 64'(a_prod_ready), 0);
        drive(1, 16'd5, 1, 0, 0);
        check("bp_release", 64'(a_acc_valid), 0);
        check("bp_cnt", 64'(a_term_cnt), 0);
        for (int i = 0; i < LEN; i++) drive(1, 16'd1, 0, 0, 0);
        check("ones_sum", 64'(a_acc_out), 8);
        drive(0, 0, 1, 0, 0);

        // Gapped input
        for (int i = 0; i < 2 * LEN; i++) drive(i % 2 == 0, (i % 2 == 0) ? gap_vals[i / 2] : 16'hffff, 0, 0, 0);
        check("gap_sum", 64'(a_acc_out), 64'd287);
        drive(0, 0, 1, 0, 0);

        // Clear mid-operation discards the coincident product
        for (int i = 0; i < 3; i++) drive(1, 16'd100, 0, 0, 0);
        drive(1, 16'd500, 0, 1, 0);
        check("clr_cnt", 64'(a_term_cnt), 0);
        for (int i = 0; i < LEN; i++) drive(1, 16'd2, 0, 0, 0);
        check("clr_sum", 64'(a_acc_out), 16);
        drive(0, 0, 1, 0, 0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) drive(1, 16'($urandom), 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        check("mrst_acc_out", 64'(a_acc_out), 0);
        check("mrst_cnt", 64'(a_term_cnt), 0);
        for (int i = 0; i < LEN; i++) drive(1, 16'($urandom), 0, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Randomized traffic with occasional clear, reset and full-scale products
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 150) == 0);
        end
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
